// File: rtl/dmem_line_responder.sv
// dmem_line_responder
// Memory-side responder for the pipeline MEM-stage data port. Requests are
// served from a single-entry 128-bit line buffer. A miss fills the buffer from
// the line-based physical memory. Every write merges its enabled bytes into the
// buffered line and then writes the whole line back to pmem (write-through).
//
// Ports
//   clk, reset_n      : clock (rising edge) and asynchronous active-low reset
//   mem_read/write    : MEM-stage request strobes (both high is a write)
//   mem_byte_enable   : write byte lanes, [1]=high byte, [0]=low byte
//   mem_address       : byte address; bit 0 is ignored
//   mem_wdata         : write data
//   mem_rdata         : read data, valid while mem_resp=1
//   mem_resp          : one-cycle completion pulse
//   pmem_read/write   : line read / line write request to the pmem arbiter
//   pmem_address      : line-aligned pmem address (low 4 bits zero)
//   pmem_wdata        : line write data (the buffered line)
//   pmem_rdata        : line read data, valid with pmem_resp
//   pmem_resp         : pmem completion pulse
module dmem_line_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int TAG_W = ADDR_WIDTH - 4;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] FILL      = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    logic [1:0]            state;
    logic [LINE_WIDTH-1:0] buf_data;
    logic [TAG_W-1:0]      buf_tag;
    logic                  buf_valid;

    // Request fields captured at acceptance.
    logic [TAG_W-1:0]      req_tag;
    logic [2:0]            req_idx;
    logic [1:0]            req_be;
    logic [15:0]           req_wdata;
    logic                  pend_write;

    logic                  hit;
    logic                  unused_addr_bit;

    assign unused_addr_bit = mem_address[0];
    assign hit = buf_valid && (buf_tag == mem_address[ADDR_WIDTH-1:4]);

    // Overlay the enabled bytes of a 16-bit word onto one word of a line.
    function automatic logic [LINE_WIDTH-1:0] merge_word(
        input logic [LINE_WIDTH-1:0] line,
        input logic [2:0]            idx,
        input logic [1:0]            be,
        input logic [15:0]           wdata
    );
        logic [LINE_WIDTH-1:0] r;
        r = line;
        if (be[0]) r[{idx, 4'b0000} +: 8] = wdata[7:0];
        if (be[1]) r[{idx, 4'b1000} +: 8] = wdata[15:8];
        return r;
    endfunction

    function automatic logic [15:0] pick_word(
        input logic [LINE_WIDTH-1:0] line,
        input logic [2:0]            idx
    );
        return line[{idx, 4'b0000} +: 16];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            buf_data   <= '0;
            buf_tag    <= '0;
            buf_valid  <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_be     <= '0;
            req_wdata  <= '0;
            pend_write <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        req_tag    <= mem_address[ADDR_WIDTH-1:4];
                        req_idx    <= mem_address[3:1];
                        req_be     <= mem_byte_enable;
                        req_wdata  <= mem_wdata;
                        pend_write <= mem_write;
                        if (!hit) begin
                            state <= FILL;
                        end else if (mem_write) begin
                            buf_data <= merge_word(buf_data, mem_address[3:1],
                                                   mem_byte_enable, mem_wdata);
                            state    <= WRITEBACK;
                        end else begin
                            mem_rdata <= pick_word(buf_data, mem_address[3:1]);
                            state     <= RESP;
                        end
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        buf_valid <= 1'b1;
                        buf_tag   <= req_tag;
                        if (pend_write) begin
                            buf_data <= merge_word(pmem_rdata, req_idx, req_be, req_wdata);
                            state    <= WRITEBACK;
                        end else begin
                            buf_data  <= pmem_rdata;
                            mem_rdata <= pick_word(pmem_rdata, req_idx);
                            state     <= RESP;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // pmem controls decode straight from state, so an asynchronous reset
    // withdraws an outstanding request in the same cycle.
    always_comb begin
        mem_resp     = (state == RESP);
        pmem_read    = (state == FILL);
        pmem_write   = (state == WRITEBACK);
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state == FILL || state == WRITEBACK) begin
            pmem_address = {req_tag, 4'b0000};
        end
        if (state == WRITEBACK) begin
            pmem_wdata = buf_data;
        end
    end

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb_dmem_line_responder
// Directed bench for dmem_line_responder. A behavioural pmem answers line reads
// with a fixed pattern derived from the line tag (word w of tag t is
// {t[7:0]-8'h04, 5'b0, w}, so line 0x0040 holds words 0..7) and captures each
// written line. A table of request vectors covers the main paths; hand-written
// sequences cover slow pmem, address changes mid-FILL and reset mid-FILL.
module tb_dmem_line_responder;

    logic         clk;
    logic         reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    // pmem model state
    int           pmem_delay = 0;
    int           wait_cnt;
    int           fill_count = 0;
    int           wb_count = 0;
    logic [127:0] last_wb_line = '0;
    logic         overlap_seen = 1'b0;

    dmem_line_responder #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pattern_line(input logic [15:0] addr);
        logic [127:0] l;
        logic [7:0]   hi;
        hi = addr[11:4] - 8'h04;
        for (int w = 0; w < 8; w++) begin
            l[w*16 +: 16] = {hi, 5'b00000, 3'(w)};
        end
        return l;
    endfunction

    // Behavioural pmem: answers after pmem_delay extra cycles with a one-cycle pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            wait_cnt   <= 0;
        end else begin
            pmem_resp <= 1'b0;
            if ((pmem_read || pmem_write) && !pmem_resp) begin
                if (wait_cnt >= pmem_delay) begin
                    pmem_resp <= 1'b1;
                    wait_cnt  <= 0;
                    if (pmem_read) begin
                        pmem_rdata <= pattern_line(pmem_address);
                        fill_count <= fill_count + 1;
                    end else begin
                        last_wb_line <= pmem_wdata;
                        wb_count     <= wb_count + 1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pmem_read && pmem_write) overlap_seen <= 1'b1;
    end

    typedef struct {
        logic         rd;
        logic         wr;
        logic [1:0]   be;
        logic [15:0]  addr;
        logic [15:0]  wdata;
        logic [15:0]  exp_rdata;
        int           exp_fills;
        int           exp_wbs;
        logic [127:0] exp_line;
        int           exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one request, wait for mem_resp (bounded) and compare everything the
    // vector predicts, then confirm the response pulse lasts a single cycle.
    task automatic apply_stimulus(input vec_t v, input string name);
        int fills0, wbs0, lat;
        bit done;
        @(negedge clk);
        fills0 = fill_count;
        wbs0   = wb_count;
        mem_read        = v.rd;
        mem_write       = v.wr;
        mem_byte_enable = v.be;
        mem_address     = v.addr;
        mem_wdata       = v.wdata;
        lat  = 0;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_resp) done = 1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no mem_resp within 60 cycles", name);
            return;
        end
        check_output({name, " latency"}, 128'(lat), 128'(v.exp_lat));
        check_output({name, " fills"}, 128'(fill_count - fills0), 128'(v.exp_fills));
        check_output({name, " writebacks"}, 128'(wb_count - wbs0), 128'(v.exp_wbs));
        if (v.rd && !v.wr) check_output({name, " rdata"}, 128'(mem_rdata), 128'(v.exp_rdata));
        if (v.exp_wbs > 0) check_output({name, " wb line"}, last_wb_line, v.exp_line);
        @(posedge clk);
        #1;
        check_output({name, " resp pulse"}, 128'(mem_resp), 128'd0);
    endtask

    initial begin
        bit stable;
        bit resp_seen;
        int stable_cycles;
        vec_t v;

        // rd wr be addr wdata exp_rdata fills wbs line lat
        vecs[0] = '{1'b1, 1'b0, 2'b11, 16'h0046, 16'h0000, 16'h0003, 1, 0, 128'h0, 3};
        vecs[1] = '{1'b1, 1'b0, 2'b11, 16'h004E, 16'h0000, 16'h0007, 0, 0, 128'h0, 1};
        vecs[2] = '{1'b0, 1'b1, 2'b01, 16'h0042, 16'hABCD, 16'h0000, 0, 1,
                    128'h0007_0006_0005_0004_0003_0002_00CD_0000, 3};
        vecs[3] = '{1'b1, 1'b0, 2'b00, 16'h0042, 16'h0000, 16'h00CD, 0, 0, 128'h0, 1};
        vecs[4] = '{1'b0, 1'b1, 2'b10, 16'h1238, 16'hBEEF, 16'h0000, 1, 1,
                    128'h1F07_1F06_1F05_BE04_1F03_1F02_1F01_1F00, 5};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 16'h1238, 16'h0000, 16'hBE04, 0, 0, 128'h0, 1};
        vecs[6] = '{1'b1, 1'b1, 2'b11, 16'h123A, 16'h1234, 16'h0000, 0, 1,
                    128'h1F07_1F06_1234_BE04_1F03_1F02_1F01_1F00, 3};
        vecs[7] = '{1'b0, 1'b1, 2'b00, 16'h1230, 16'hFFFF, 16'h0000, 0, 1,
                    128'h1F07_1F06_1234_BE04_1F03_1F02_1F01_1F00, 3};
        vecs[8] = '{1'b1, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h0000, 1, 0, 128'h0, 3};

        reset_n         = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b00;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        #2;
        check_output("reset mem_resp", 128'(mem_resp), 128'd0);
        check_output("reset mem_rdata", 128'(mem_rdata), 128'd0);
        check_output("reset pmem_read", 128'(pmem_read), 128'd0);
        check_output("reset pmem_write", 128'(pmem_write), 128'd0);
        check_output("reset pmem_address", 128'(pmem_address), 128'd0);
        check_output("reset pmem_wdata", pmem_wdata, 128'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Slow pmem with the requester changing its address mid-FILL.
        pmem_delay = 10;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 16'h2000;
        @(posedge clk);
        #1;
        mem_address   = 16'h0040;
        stable        = 1'b1;
        stable_cycles = 0;
        for (int c = 0; c < 40 && !pmem_resp; c++) begin
            if (!pmem_read || pmem_address !== 16'h2000 || mem_resp) stable = 1'b0;
            stable_cycles++;
            @(posedge clk);
            #1;
        end
        check_output("slow pmem request stable", 128'(stable), 128'd1);
        check_output("slow pmem waited >=10", 128'(stable_cycles >= 10), 128'd1);
        @(posedge clk);
        #1;
        check_output("slow pmem resp", 128'(mem_resp), 128'd1);
        check_output("slow pmem rdata", 128'(mem_rdata), 128'hFC00);
        mem_read = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a FILL.
        pmem_delay = 5;
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 16'h0046;
        @(posedge clk);
        #1;
        check_output("midfill pmem_read up", 128'(pmem_read), 128'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midfill reset pmem_read", 128'(pmem_read), 128'd0);
        check_output("midfill reset pmem_address", 128'(pmem_address), 128'd0);
        mem_read  = 1'b0;
        resp_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_seen = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) resp_seen = 1'b1;
        end
        check_output("midfill no mem_resp", 128'(resp_seen), 128'd0);
        pmem_delay = 0;

        // The line buffered before reset must miss afterwards.
        v = '{1'b1, 1'b0, 2'b11, 16'h2000, 16'h0000, 16'hFC00, 1, 0, 128'h0, 3};
        apply_stimulus(v, "post-reset 0x2000");
        v = '{1'b1, 1'b0, 2'b11, 16'h0046, 16'h0000, 16'h0003, 1, 0, 128'h0, 3};
        apply_stimulus(v, "post-reset 0x0046");

        check_output("pmem read/write overlap", 128'(overlap_seen), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
